// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request/response port: one requester-side bundle carrying
// request fields toward the memory and addr_ok/data_ok/rdata back.
interface sram_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req;
  logic                  wr;
  logic [1:0]            size;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     wdata;
  logic                  addr_ok;
  logic                  data_ok;
  logic [DATA_W-1:0]     rdata;

  // Issues requests, receives handshakes and read data
  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  // Accepts requests, returns handshakes and read data
  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and the data
// requester. Data has fixed priority; a grant is held until the address
// handshake completes (or the owner withdraws its request). A small in-order
// tag FIFO remembers who issued each outstanding transaction so data_ok can be
// routed back to the right requester.
module sram_req_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 2
) (
  input  logic               clk,
  input  logic               resetn,
  sram_req_arbiter_if.slave  ibus,
  sram_req_arbiter_if.slave  dbus,
  sram_req_arbiter_if.master mbus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_OUT) + 1;
  localparam int PTR_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [MAX_OUT-1:0] tag_mem;   // 0 = inst, 1 = data

  logic               sel_req;
  logic               sel_wr;
  logic [1:0]         sel_size;
  logic [ADDR_W-1:0]  sel_addr;
  logic [STRB_W-1:0]  sel_wstrb;
  logic [DATA_W-1:0]  sel_wdata;

  logic               slot_free;
  logic               push;
  logic               pop;
  logic               head;

  // Pointers wrap modulo MAX_OUT, which need not fill the pointer width
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Owner's request fields drive the shared port; nothing is driven in IDLE
  always_comb begin
    sel_req   = 1'b0;
    sel_wr    = 1'b0;
    sel_size  = 2'd0;
    sel_addr  = '0;
    sel_wstrb = '0;
    sel_wdata = '0;
    case (state)
      GNT_I: begin
        sel_req   = ibus.req;
        sel_wr    = ibus.wr;
        sel_size  = ibus.size;
        sel_addr  = ibus.addr;
        sel_wstrb = ibus.wstrb;
        sel_wdata = ibus.wdata;
      end
      GNT_D: begin
        sel_req   = dbus.req;
        sel_wr    = dbus.wr;
        sel_size  = dbus.size;
        sel_addr  = dbus.addr;
        sel_wstrb = dbus.wstrb;
        sel_wdata = dbus.wdata;
      end
      default: ;
    endcase
  end

  assign mbus.req   = sel_req;
  assign mbus.wr    = sel_wr;
  assign mbus.size  = sel_size;
  assign mbus.addr  = sel_addr;
  assign mbus.wstrb = sel_wstrb;
  assign mbus.wdata = sel_wdata;

  assign slot_free = (cnt < CNT_FULL);
  assign push      = mbus.req & mbus.addr_ok;
  assign pop       = mbus.data_ok & (cnt != '0);
  assign head      = tag_mem[rd_ptr];

  // Only the current owner sees the address handshake
  assign ibus.addr_ok = (state == GNT_I) & mbus.addr_ok;
  assign dbus.addr_ok = (state == GNT_D) & mbus.addr_ok;

  // Responses return in issue order; the FIFO head says whose response it is
  assign ibus.data_ok = pop & ~head;
  assign dbus.data_ok = pop &  head;
  assign ibus.rdata   = mbus.rdata;
  assign dbus.rdata   = mbus.rdata;

  // Grant FSM and FIFO occupancy; a grant is dropped only on handshake or withdrawal
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (slot_free && dbus.req) begin
            state <= GNT_D;
          end else if (slot_free && ibus.req) begin
            state <= GNT_I;
          end
        end
        GNT_I: if (!ibus.req || mbus.addr_ok) state <= IDLE;
        GNT_D: if (!dbus.req || mbus.addr_ok) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);

      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Tag storage is plain data and needs no reset; validity comes from cnt
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= (state == GNT_D);
  end

  // A response with nothing outstanding is dropped; flag it in simulation
  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(mbus.data_ok && (cnt == '0)))
      else $warning("sram_req_arbiter: m_data_ok with no outstanding transaction ignored");
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: a linear sequence of steps drives both
// requesters and the shared port; expected responses are queued at issue time
// and matched in order against i/d data_ok as they appear.
module tb_sram_req_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  sram_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ib ();
  sram_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) db ();
  sram_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mb ();

  sram_req_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .MAX_OUT(2)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .ibus  (ib),
    .dbus  (db),
    .mbus  (mb)
  );

  typedef struct packed {
    logic          is_d;
    logic [DW-1:0] data;
  } resp_t;

  resp_t exp_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  int    n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic is_d, input logic [DW-1:0] d);
    resp_t r;
    r.is_d = is_d;
    r.data = d;
    exp_q.push_back(r);
  endtask

  task automatic idle_inputs();
    ib.req = 1'b0; ib.wr = 1'b0; ib.size = 2'd2; ib.addr = '0; ib.wstrb = '0; ib.wdata = '0;
    db.req = 1'b0; db.wr = 1'b0; db.size = 2'd2; db.addr = '0; db.wstrb = '0; db.wdata = '0;
    mb.addr_ok = 1'b0; mb.data_ok = 1'b0; mb.rdata = '0;
  endtask

  // Scoreboard: every routed response must match the oldest queued expectation
  always @(negedge clk) begin
    resp_t e;
    if (resetn === 1'b1 && (ib.data_ok === 1'b1 || db.data_ok === 1'b1)) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", {30'b0, ib.data_ok, db.data_ok}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk1("resp_i_ok", ib.data_ok, ~e.is_d);
        chk1("resp_d_ok", db.data_ok, e.is_d);
        chk("resp_rdata", e.is_d ? db.rdata : ib.rdata, e.data);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    idle_inputs();

    // ---- 1: reset state, then a lone inst request ----
    ib.req = 1'b1; ib.addr = 32'h0000_1000;
    mb.addr_ok = 1'b1;
    tick();
    tick();
    #1;
    chk1("rst_m_req", mb.req, 1'b0);
    chk1("rst_i_addr_ok", ib.addr_ok, 1'b0);
    chk1("rst_d_addr_ok", db.addr_ok, 1'b0);
    chk1("rst_i_data_ok", ib.data_ok, 1'b0);
    chk1("rst_d_data_ok", db.data_ok, 1'b0);

    push_exp(1'b0, 32'h1234_5678);
    resetn = 1'b1;
    #1;
    chk1("t1_m_req_c0", mb.req, 1'b0);
    tick();
    #1;
    chk1("t1_m_req_c1", mb.req, 1'b1);
    chk1("t1_i_addr_ok", ib.addr_ok, 1'b1);
    chk1("t1_d_addr_ok", db.addr_ok, 1'b0);
    chk("t1_m_addr", mb.addr, 32'h0000_1000);
    chk1("t1_m_wr", mb.wr, 1'b0);
    tick();
    ib.req = 1'b0;
    #1;
    chk1("t1_m_req_done", mb.req, 1'b0);
    chk1("t1_i_addr_ok_done", ib.addr_ok, 1'b0);
    tick();
    mb.data_ok = 1'b1; mb.rdata = 32'h1234_5678;
    #1;
    chk1("t1_i_data_ok", ib.data_ok, 1'b1);
    chk("t1_i_rdata", ib.rdata, 32'h1234_5678);
    chk1("t1_d_data_ok", db.data_ok, 1'b0);
    tick();
    mb.data_ok = 1'b0; mb.rdata = '0;

    // ---- 2: simultaneous requests, data wins ----
    db.req = 1'b1; db.wr = 1'b1; db.addr = 32'h2000_0040; db.wstrb = 4'hF; db.wdata = 32'hCAFE_F00D;
    ib.req = 1'b1; ib.addr = 32'h0000_1004;
    push_exp(1'b1, 32'hD2D2_0001);
    push_exp(1'b0, 32'h1212_0002);
    #1;
    chk1("t2_idle_m_req", mb.req, 1'b0);
    tick();
    #1;
    chk1("t2_d_addr_ok", db.addr_ok, 1'b1);
    chk1("t2_i_addr_ok_blocked", ib.addr_ok, 1'b0);
    chk("t2_m_addr_d", mb.addr, 32'h2000_0040);
    chk1("t2_m_wr", mb.wr, 1'b1);
    chk("t2_m_wdata", mb.wdata, 32'hCAFE_F00D);
    chk("t2_m_wstrb", {28'b0, mb.wstrb}, 32'hF);
    tick();
    db.req = 1'b0; db.wr = 1'b0;
    #1;
    chk1("t2_gap_m_req", mb.req, 1'b0);
    chk1("t2_gap_i_addr_ok", ib.addr_ok, 1'b0);
    tick();
    #1;
    chk1("t2_i_addr_ok", ib.addr_ok, 1'b1);
    chk1("t2_d_addr_ok_off", db.addr_ok, 1'b0);
    chk("t2_m_addr_i", mb.addr, 32'h0000_1004);
    tick();
    ib.req = 1'b0;
    mb.data_ok = 1'b1; mb.rdata = 32'hD2D2_0001;
    #1;
    chk1("t2_resp1_d", db.data_ok, 1'b1);
    chk1("t2_resp1_i", ib.data_ok, 1'b0);
    tick();
    mb.rdata = 32'h1212_0002;
    #1;
    chk1("t2_resp2_i", ib.data_ok, 1'b1);
    chk1("t2_resp2_d", db.data_ok, 1'b0);
    tick();
    mb.data_ok = 1'b0; mb.rdata = '0;

    // ---- 3: FIFO full stalls grants until one pop ----
    ib.req = 1'b1; ib.addr = 32'h0000_1100;
    push_exp(1'b0, 32'h3100_0001);
    tick();
    #1;
    chk1("t3_grant1", mb.req, 1'b1);
    tick();
    ib.addr = 32'h0000_1104;
    push_exp(1'b0, 32'h3100_0002);
    #1;
    chk1("t3_gap1", mb.req, 1'b0);
    tick();
    #1;
    chk1("t3_grant2", mb.req, 1'b1);
    chk("t3_grant2_addr", mb.addr, 32'h0000_1104);
    tick();
    ib.addr = 32'h0000_1108;
    push_exp(1'b0, 32'h3100_0003);
    #1;
    chk1("t3_full_a", mb.req, 1'b0);
    tick();
    #1;
    chk1("t3_full_b", mb.req, 1'b0);
    tick();
    #1;
    chk1("t3_full_c", mb.req, 1'b0);
    mb.data_ok = 1'b1; mb.rdata = 32'h3100_0001;
    tick();
    mb.data_ok = 1'b0;
    #1;
    chk1("t3_after_pop", mb.req, 1'b0);
    tick();
    #1;
    chk1("t3_regrant", mb.req, 1'b1);
    chk("t3_regrant_addr", mb.addr, 32'h0000_1108);
    tick();
    ib.req = 1'b0;
    mb.data_ok = 1'b1; mb.rdata = 32'h3100_0002;
    tick();
    mb.rdata = 32'h3100_0003;
    tick();
    mb.data_ok = 1'b0; mb.rdata = '0;

    // ---- 4: address handshake stalled while data holds the grant ----
    db.req = 1'b1; db.wr = 1'b1; db.size = 2'd1; db.addr = 32'h2000_0080;
    db.wstrb = 4'h3; db.wdata = 32'h0BAD_BEEF;
    ib.req = 1'b1; ib.addr = 32'h0000_1200;
    mb.addr_ok = 1'b0;
    push_exp(1'b1, 32'h4D4D_0001);
    push_exp(1'b0, 32'h4141_0002);
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      chk1("t4_hold_m_req", mb.req, 1'b1);
      chk("t4_hold_m_addr", mb.addr, 32'h2000_0080);
      chk("t4_hold_m_wdata", mb.wdata, 32'h0BAD_BEEF);
      chk1("t4_hold_i_addr_ok", ib.addr_ok, 1'b0);
      chk1("t4_hold_d_addr_ok", db.addr_ok, 1'b0);
    end
    mb.addr_ok = 1'b1;
    #1;
    chk1("t4_d_addr_ok", db.addr_ok, 1'b1);
    chk("t4_m_size", {30'b0, mb.size}, 32'd1);
    tick();
    db.req = 1'b0; db.wr = 1'b0; db.size = 2'd2;
    #1;
    chk1("t4_gap_m_req", mb.req, 1'b0);
    tick();
    #1;
    chk1("t4_i_addr_ok", ib.addr_ok, 1'b1);
    chk("t4_m_addr_i", mb.addr, 32'h0000_1200);
    tick();
    ib.req = 1'b0;
    mb.data_ok = 1'b1; mb.rdata = 32'h4D4D_0001;
    tick();
    mb.rdata = 32'h4141_0002;
    tick();
    mb.data_ok = 1'b0; mb.rdata = '0;

    // ---- 5: alternating I/D stream, push and pop together, pointers wrap ----
    for (int n = 0; n < 10; n++) begin
      if (n % 2 == 1) begin
        ib.req = 1'b0;
        db.req = 1'b1; db.addr = 32'h2000_1000 + 32'(n * 4);
        push_exp(1'b1, 32'h5A00_0000 + 32'(n));
      end else begin
        db.req = 1'b0;
        ib.req = 1'b1; ib.addr = 32'h0000_3000 + 32'(n * 4);
        push_exp(1'b0, 32'h5A00_0000 + 32'(n));
      end
      mb.data_ok = 1'b0;
      tick();
      #1;
      if (n % 2 == 1) begin
        chk1("t5_d_addr_ok", db.addr_ok, 1'b1);
        chk1("t5_i_addr_ok_off", ib.addr_ok, 1'b0);
      end else begin
        chk1("t5_i_addr_ok", ib.addr_ok, 1'b1);
        chk1("t5_d_addr_ok_off", db.addr_ok, 1'b0);
      end
      if (n > 0) begin
        mb.data_ok = 1'b1; mb.rdata = 32'h5A00_0000 + 32'(n - 1);
      end
      tick();
    end
    ib.req = 1'b0; db.req = 1'b0;
    mb.data_ok = 1'b1; mb.rdata = 32'h5A00_0009;
    tick();
    mb.data_ok = 1'b0; mb.rdata = '0;

    // ---- 6: spurious response, then reset with the FIFO full ----
    tick();
    mb.data_ok = 1'b1; mb.rdata = 32'hDEAD_0000;
    #1;
    chk1("t6_spur_i_data_ok", ib.data_ok, 1'b0);
    chk1("t6_spur_d_data_ok", db.data_ok, 1'b0);
    tick();
    mb.data_ok = 1'b0; mb.rdata = '0;

    db.req = 1'b1; db.addr = 32'h2000_2000;
    tick();
    tick();
    db.addr = 32'h2000_2004;
    tick();
    tick();
    db.addr = 32'h2000_2008;
    #1;
    chk1("t6_full_a", mb.req, 1'b0);
    tick();
    #1;
    chk1("t6_full_b", mb.req, 1'b0);
    resetn = 1'b0;
    mb.addr_ok = 1'b0;
    tick();
    #1;
    chk1("t6_rst_m_req", mb.req, 1'b0);
    chk1("t6_rst_d_addr_ok", db.addr_ok, 1'b0);
    resetn = 1'b1;
    #1;
    chk1("t6_post_rst_idle", mb.req, 1'b0);
    tick();
    #1;
    chk1("t6_post_rst_grant", mb.req, 1'b1);
    chk("t6_post_rst_addr", mb.addr, 32'h2000_2008);
    chk1("t6_post_rst_addr_ok", db.addr_ok, 1'b0);
    db.req = 1'b0;
    #1;
    chk1("t6_withdraw_m_req", mb.req, 1'b0);
    tick();
    #1;
    chk1("t6_withdraw_idle", mb.req, 1'b0);
    tick();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
